// File: rtl/demux8_deser.sv
// Serial-to-parallel receiver: a 3-bit index steers each accepted bit into a
// capture buffer; the completed byte is published on q with a one-cycle done pulse.
module demux8_deser #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       din,
    input  logic       din_valid,
    output logic [7:0] q,
    output logic [2:0] sel,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] shbuf_q, shbuf_d;
    logic [7:0] word_q, word_d;
    logic [2:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [2:0] idx;
    logic [7:0] merged;

    // Buffer with the current bit already in place; used both for the running
    // capture and for the final publish so the last bit is not lost.
    always_comb begin
        idx         = MSB_FIRST ? (3'd7 - sel_q) : sel_q;
        merged      = shbuf_q;
        merged[idx] = din;
    end

    always_comb begin
        state_d = state_q;
        shbuf_d = shbuf_q;
        word_d  = word_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    sel_d   = 3'd0;
                    shbuf_d = 8'h00;
                end
            end
            SHIFT: begin
                if (start) begin
                    sel_d   = 3'd0;
                    shbuf_d = 8'h00;
                end else if (din_valid) begin
                    shbuf_d = merged;
                    if (sel_q == 3'd7) begin
                        word_d  = merged;
                        sel_d   = 3'd0;
                        state_d = DONE;
                    end else begin
                        sel_d = sel_q + 3'd1;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    sel_d   = 3'd0;
                    shbuf_d = 8'h00;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 3'd0;
                shbuf_d = 8'h00;
            end
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shbuf_q <= 8'h00;
            word_q  <= 8'h00;
            sel_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shbuf_q <= shbuf_d;
            word_q  <= word_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q    = word_q;
    assign sel  = sel_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/demux8_deser.md
# demux8_deser

Serial-to-parallel receiver for the 8:1 mux datapath. The 8:1 mux serializes eight lines A..H, one per step of a 3-bit select counting 000..111. This block is the receiving end: a 3-bit index counter steers each incoming bit through a 1-to-8 demux into a capture buffer. It presents the completed 8-bit word with a one-cycle completion pulse. It sits downstream of the mux/serializer and feeds parallel consumers such as display and LED logic.

## Interface
- MSB_FIRST, default 0, bit ordering of the stream.
  - 0: bit received at index i lands in q[i] (A→q[0] … H→q[7]).
  - 1: bit received at index i lands in q[7-i].
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset; synchronous and active-low, one clock
- start  input  1  arms or restarts reception of a frame
- din  input  1  serial data bit
- din_valid  input  1  din is valid this cycle (qualified only in SHIFT)
- q  output  8  last completed word, held until the next completed frame
- sel  output  3  current demux index, i.e. the number of bits accepted in this frame
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse when q is updated

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 → SHIFT.
  - At that edge: sel←0, internal buffer buf←0.
  - din is ignored in IDLE.
- SHIFT, each edge with din_valid=1:
  - buf[idx(sel)]←din, where idx(sel)=sel if MSB_FIRST=0, else 7-sel.
  - If sel≠7: sel←sel+1.
  - If sel=7: q←buf with the final bit merged in, sel←0 (3-bit wrap), state→DONE.
- SHIFT with din_valid=0: stall. sel, buf and state hold; there is no timeout.
- DONE: done=1 for exactly this cycle.
  - start=0 → IDLE.
  - start=1 → SHIFT, sel←0, buf←0. The new frame starts without passing through IDLE.
- start=1 while in SHIFT: abort and restart.
  - sel←0, buf←0, stay in SHIFT.
  - din on that cycle is discarded even if din_valid=1.
  - q is unchanged and done is not asserted.
- start has priority over din_valid in every state.
- q changes only on a frame completion. Partial frames never appear on q.
- rst_n=0 at a clock edge overrides everything, including reset in the middle of a frame. Resulting state:
  - state=IDLE
  - q=8'h00, buf=8'h00, sel=3'b000
  - busy=0, done=0

## Timing
- Reset values of all outputs: q=8'h00, sel=3'b000, busy=0, done=0.
- Latency from start: start sampled at edge t0 → busy=1 from t0+1.
  - The first bit can be accepted at edge t0+1 at the earliest.
- Latency of a frame: the 8th valid bit is sampled at edge tn.
  - q holds the new word and done=1 during cycle tn+1.
  - busy=0 during cycle tn+1.
- Minimum frame length is 8 cycles of SHIFT plus 1 cycle of DONE.
  - With start held during DONE, frames are back-to-back at 9 cycles per frame.
- Output register type:
  - sel, busy, done and q are registered; there are no combinational paths from input to output.
  - sel is visible during SHIFT and reads 0 in IDLE and DONE.

## Test plan
- Reset check: hold rst_n=0 for 2 cycles with start=1 and din_valid=1.
  - Required: q=8'h00, sel=0, busy=0, done=0 throughout; the block remains in IDLE after release until start is applied.
- Mux-pattern frame, MSB_FIRST=0: start, then din = 0,1,1,0,1,0,0,1 with din_valid=1 on consecutive cycles. This matches A..H of the mux test vector with select values 000..111.
  - Required: q=8'h96, with done=1 for exactly one cycle, one cycle after the 8th bit.
  - Required: sel steps 0..7 as the bits are accepted.
- Same stream with MSB_FIRST=1.
  - Required: q=8'h69 and done pulses once.
- Stall: same stream as the mux-pattern frame, with din_valid=0 for 3 cycles after the 4th bit.
  - Required: sel holds at 4 during the stall; q=8'h96 at completion; done arrives 3 cycles later than in the unstalled run.
- Abort: sequence as follows.
  - Send 5 bits 1,1,1,1,1.
  - Assert start together with din=1 and din_valid=1.
  - Send 8 bits all 0.
  - Required: q=8'h00 and a single done pulse.
  - Required: sel returns to 0 on the abort; no done pulse before the second frame completes.
- Back-to-back frames with start held during DONE: frame 1 = 0x96 pattern, frame 2 = all 1s.
  - Required: done pulses 9 cycles apart; q=8'h96, then 8'hFF.
  - Repeat with rst_n=0 asserted mid-frame-2: required q=8'h00 and no done pulse.
